// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks.
//   ps2_state_e      : transmit FSM states (IDLE .. WAIT_IDLE)
//   CMD_* / RESP_*   : common host->device command bytes and device reply
//   KEY_*            : scan-code constants (9 bits: {extended, code})
//   EDGE_*           : falling-edge numbers within one host->device frame
//   odd_parity()     : parity bit that makes the 9-bit {parity,data} odd
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } ps2_state_e;

    // Host -> keyboard commands and the keyboard's acknowledge byte.
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RESP_ACK    = 8'hFA;

    // Scan codes, bit 8 set for E0-prefixed keys.
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_A     = 9'h01C;
    localparam logic [8:0] KEY_D     = 9'h023;

    // Falling edge numbers: 1 = data bit 0 ... 8 = bit 7, 9 parity,
    // 10 stop, 11 device acknowledge.
    localparam logic [3:0] EDGE_LAST_DATA = 4'd7;  // count value when bit 7 is driven
    localparam logic [3:0] EDGE_ACK       = 4'd11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Brings one asynchronous PS/2 line into the clk domain and flags its
// falling edges.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset (stages preset to 1, i.e. idle)
//   line   : raw PS/2 line (open-drain, pulled high externally)
//   synced : line after a 2-FF synchroniser
//   fall   : one-cycle pulse when synced goes 1 -> 0 on consecutive cycles
// ---------------------------------------------------------------------------
module ps2_sync_edge
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic synced,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to 1 so a line that is idle at reset release does not look
    // like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign synced = sync_q;
    assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Sends one command byte from the host to a PS/2 device: request-to-send
// (clock inhibit), start bit, 8 data bits LSB first, odd parity, stop bit,
// then checks the device acknowledge and waits for both lines to go idle.
//
// Parameters
//   INHIBIT_CYCLES : clk cycles PS2_CLK is held low before the start bit
//   TIMEOUT_CYCLES : frame time limit in clk cycles (timeout build only)
//
// Ports
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   tx_data   : byte to send, captured when tx_valid && tx_ready
//   tx_valid  : send request
//   tx_ready  : high only in IDLE
//   tx_done   : one-cycle pulse, frame sent and ACK seen, lines idle again
//   tx_error  : one-cycle pulse, no ACK (or timeout)
//   PS2_CLK   : open-drain clock line (driven 0 or released)
//   PS2_DATA  : open-drain data line (driven 0 or released)
//   state_dbg : current FSM state
//
// Handshake: a transfer happens in a cycle where tx_valid && tx_ready are
// both high; tx_valid while tx_ready is low is dropped, never queued.
//
// Build option: define PS2_TX_TIMEOUT_EN to abort a frame that has not
// finished TIMEOUT_CYCLES cycles after acceptance. Without it a silent
// device leaves the block waiting until rst.
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA,
    output ps2_state_e state_dbg
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    // Line synchronisers
    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic unused_data_fall;

    ps2_sync_edge u_sync_clk (
        .clk    (clk),
        .rst    (rst),
        .line   (PS2_CLK),
        .synced (clk_sync),
        .fall   (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk    (clk),
        .rst    (rst),
        .line   (PS2_DATA),
        .synced (data_sync),
        .fall   (unused_data_fall)
    );

    // State and datapath registers
    ps2_state_e       state_q,   state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;   // falling edges seen, 0..11
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             bit_val_q, bit_val_d;   // level currently presented on PS2_DATA

    logic clk_low;
    logic data_low;
    logic ready_c;
    logic done_c;
    logic err_c;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int FRAME_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               timeout;

    // frame_cnt is 1 in the first cycle after acceptance, so timeout fires
    // in the TIMEOUT_CYCLES-th cycle after the accepting cycle.
    assign timeout = (state_q != ST_IDLE) &&
                     (frame_cnt_q == FRAME_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            inh_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_byte_q <= '0;
            bit_val_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_byte_q <= tx_byte_d;
            bit_val_q <= bit_val_d;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_byte_d = tx_byte_q;
        bit_val_d = bit_val_q;
        clk_low   = 1'b0;
        data_low  = 1'b0;
        ready_c   = 1'b0;
        done_c    = 1'b0;
        err_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c   = 1'b1;
                inh_cnt_d = '0;
                bit_cnt_d = '0;
                bit_val_d = 1'b1;
                if (tx_valid) begin
                    tx_byte_d = tx_data;
                    state_d   = ST_INHIBIT;
                end
            end

            // Request-to-send: clock low for INHIBIT_CYCLES cycles, data
            // pulled low in the last one so the start bit is already in
            // place when the clock is released.
            ST_INHIBIT: begin
                clk_low = 1'b1;
                if (inh_cnt_q == INH_LAST) begin
                    data_low = 1'b1;
                    state_d  = ST_START;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            ST_START: begin
                data_low = 1'b1;
                if (clk_fall) begin
                    bit_cnt_d = 4'd1;
                    bit_val_d = tx_byte_q[0];
                    state_d   = ST_DATA;
                end
            end

            // bit_cnt_q = k (1..7) means edge k+1 is next and puts bit k out.
            ST_DATA: begin
                data_low = ~bit_val_q;
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    bit_val_d = tx_byte_q[bit_cnt_q[2:0]];
                    if (bit_cnt_q == EDGE_LAST_DATA) begin
                        state_d = ST_PARITY;
                    end
                end
            end

            ST_PARITY: begin
                data_low = ~bit_val_q;
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    bit_val_d = odd_parity(tx_byte_q);
                    state_d   = ST_STOP;
                end
            end

            // Parity still on the line until edge 10 replaces it with the
            // stop bit (released line).
            ST_STOP: begin
                data_low = ~bit_val_q;
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    bit_val_d = 1'b1;
                    state_d   = ST_ACK;
                end
            end

            ST_ACK: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (!data_sync) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        err_c   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        frame_cnt_d = frame_cnt_q;
        if (state_q == ST_IDLE) begin
            frame_cnt_d = tx_valid ? FRAME_W'(1) : '0;
        end else if (!timeout) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        // A frame that completes in the same cycle wins over the timeout,
        // so done and error never coincide.
        if (timeout && !done_c) begin
            clk_low  = 1'b0;
            data_low = 1'b0;
            err_c    = 1'b1;
            state_d  = ST_IDLE;
        end
`endif
    end

    // While rst is high the lines are released and the outputs show the
    // idle values even before the first reset edge.
    assign tx_ready  = rst | ready_c;
    assign tx_done   = ~rst & done_c;
    assign tx_error  = ~rst & err_c;
    assign state_dbg = state_q;

    assign PS2_CLK  = (~rst & clk_low)  ? 1'b0 : 1'bz;
    assign PS2_DATA = (~rst & data_low) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a behavioural PS/2 device: the device detects
// request-to-send, generates 11 clock pulses with randomised high/low
// widths, samples PS2_DATA before each rising clock edge and optionally
// acknowledges. Expected frames come from the byte's bit list plus an
// odd-parity bit computed by counting ones.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TMO = 5000;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    ps2_state_e state_dbg;

    wire  ps2_clk;
    wire  ps2_data;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    int   dev_h = 4;
    int   dev_l = 7;

    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .PS2_CLK   (ps2_clk),
        .PS2_DATA  (ps2_data),
        .state_dbg (state_dbg)
    );

    // Scoreboard
    int checks   = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    // Pulse monitor
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   both_cnt = 0;
    int   rdy_after_err_cnt = 0;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        if (tx_done)              done_cnt <= done_cnt + 1;
        if (tx_error)             err_cnt  <= err_cnt + 1;
        if (tx_done && tx_error)  both_cnt <= both_cnt + 1;
        if (err_prev && tx_ready) rdy_after_err_cnt <= rdy_after_err_cnt + 1;
        err_prev <= tx_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: {stop, parity, data[7:0]} in the order the device
    // samples them (data LSB first).
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        int ones;
        logic par;
        ones = $countones(d);
        par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    // Driver: request a byte, inject an ignored second request during the
    // inhibit phase, measure the inhibit length and the start bit.
    task automatic send_start(input logic [7:0] d);
        int n;
        int cnt;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        exp_q.push_back(frame_of(d));
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        cnt = 0;
        while (ps2_clk === 1'b0 && cnt < INH + 50) begin
            cnt++;
            if (cnt == 3) begin
                tx_valid = 1'b1;
                tx_data  = ~d;
            end
            if (cnt == 4) tx_valid = 1'b0;
            if (cnt == INH) check("data_low_last_inhibit", 32'(ps2_data), 32'd0);
            @(negedge clk);
        end
        check("inhibit_len", 32'(cnt), 32'(INH));
        check("start_bit", 32'(ps2_data), 32'd0);
        check("busy_ready", 32'(tx_ready), 32'd0);
    endtask

    // Behavioural device: n_edges clock pulses, data sampled just before
    // each rising edge; on pulse 11 it drives ACK low if ack_low.
    task automatic device_clock(input int n_edges, input bit ack_low, output logic [9:0] bits);
        bits = '0;
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11) dev_data_low = ack_low;
            repeat (dev_h) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (dev_l) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_data;
            dev_clk_low = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack_low);
        logic [9:0] bits;
        logic [9:0] exp_frame;
        int d0;
        int e0;
        int r0;
        int n;
        d0 = done_cnt;
        e0 = err_cnt;
        r0 = rdy_after_err_cnt;
        send_start(d);
        device_clock(11, ack_low, bits);
        exp_frame = exp_q.pop_front();
        check("frame_bits", 32'(bits), 32'(exp_frame));
        if (ack_low) begin
            // Data still held low by the device: must not complete yet.
            repeat (5) @(negedge clk);
            check("wait_idle_hold", 32'(done_cnt - d0), 32'd0);
            dev_data_low = 1'b0;
            n = 0;
            while (tx_done !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("done_seen", 32'(tx_done), 32'd1);
            check("ready_during_done", 32'(tx_ready), 32'd0);
            @(negedge clk);
            check("ready_after_done", 32'(tx_ready), 32'd1);
            check("done_width", 32'(tx_done), 32'd0);
            repeat (3) @(negedge clk);
            check("done_count", 32'(done_cnt - d0), 32'd1);
            check("no_err_on_ack", 32'(err_cnt - e0), 32'd0);
        end else begin
            repeat (4) @(negedge clk);
            check("err_count", 32'(err_cnt - e0), 32'd1);
            check("ready_after_err", 32'(rdy_after_err_cnt - r0), 32'd1);
            check("no_done_on_nack", 32'(done_cnt - d0), 32'd0);
        end
        // The request injected during the inhibit phase must not start a frame.
        check("no_queued_frame", 32'(ps2_clk), 32'd1);
        check("idle_ready", 32'(tx_ready), 32'd1);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [9:0] partial;
        logic [7:0] d;
        int d0;
        int e0;
        int n;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        check("rst_clk_line", 32'(ps2_clk), 32'd1);
        check("rst_data_line", 32'(ps2_data), 32'd1);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames: set-LED command and parity corner bytes
        run_frame(CMD_SET_LED, 1'b1);
        run_frame(8'h00, 1'b1);
        run_frame(8'hFF, 1'b1);
        run_frame(8'h01, 1'b1);

        // Missing ACK
        run_frame(8'h5A, 1'b0);

        // Randomised frames
        for (int i = 0; i < 6; i++) begin
            dev_h = $urandom_range(3, 8);
            dev_l = $urandom_range(6, 10);
            d     = 8'($urandom);
            run_frame(d, ($urandom_range(0, 3) != 0));
        end
        dev_h = 4;
        dev_l = 7;

        // Reset after falling edge 5
        d0 = done_cnt;
        e0 = err_cnt;
        send_start(8'h00);
        device_clock(5, 1'b0, partial);
        void'(exp_q.pop_front());
        check("mid_frame_data_driven", 32'(ps2_data), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_clk_line", 32'(ps2_clk), 32'd1);
        check("mid_rst_data_line", 32'(ps2_data), 32'd1);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
        run_frame(CMD_RESET, 1'b1);

        // Silent device
        e0 = err_cnt;
        send_start(8'hA3);
        void'(exp_q.pop_front());
`ifdef PS2_TX_TIMEOUT_EN
        // send_start returns at the (INH+1)-th negedge after acceptance.
        n = INH + 1;
        while (tx_error !== 1'b1 && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycle", 32'(n), 32'(TMO));
        check("timeout_lines_released", 32'(ps2_data), 32'd1);
        @(negedge clk);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        check("timeout_err_width", 32'(tx_error), 32'd0);
        repeat (2) @(negedge clk);
        check("timeout_err_count", 32'(err_cnt - e0), 32'd1);
`else
        repeat (300) @(negedge clk);
        check("silent_still_busy", 32'(tx_ready), 32'd0);
        check("silent_no_err", 32'(err_cnt - e0), 32'd0);
        check("silent_start_held", 32'(ps2_data), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("silent_rst_ready", 32'(tx_ready), 32'd1);
`endif

        // Recovery after the silent device
        run_frame(CMD_SET_LED, 1'b1);

        check("never_done_and_error", 32'(both_cnt), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
